// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read master: FSM states, response error codes
// and the AXI RRESP encodings.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } axi_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // OKAY/EXOKAY are success to the core; SLVERR/DECERR collapse to one slave error.
    function automatic logic [1:0] map_rresp(input logic [1:0] rresp);
        map_rresp = ERR_OK;
        case (rresp)
            RRESP_OKAY, RRESP_EXOKAY:   map_rresp = ERR_OK;
            RRESP_SLVERR, RRESP_DECERR: map_rresp = ERR_SLAVE;
        endcase
    endfunction

endpackage

// File: rtl/axi_timeout_ctr.sv
// Per-phase wait counter: expired is high during the LIMIT-th enabled cycle
// after a clear, so the owner can leave the phase on that same edge.
module axi_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    assign expired = enable && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_master.sv
// Single-outstanding AXI read master: turns a core request into an AR/R
// transaction and returns data or an error code, with a per-phase timeout.
module axi_read_master
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_err,
    output logic                  R_EN,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP
);
    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] ADDR = 2'(ST_ADDR);
    localparam logic [1:0] DATA = 2'(ST_DATA);
    localparam logic [1:0] RESP = 2'(ST_RESP);

    logic [1:0] state;
    logic       accept;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;

    // req_ready is itself the IDLE-and-out-of-reset qualifier for acceptance.
    assign accept     = (state == IDLE) && req_ready && req_valid;
    assign tmo_clear  = accept || ((state == ADDR) && ARREADY);
    assign tmo_enable = (state == ADDR) || (state == DATA);

    axi_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Every output is a flop updated on the transition that changes it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= ERR_OK;
            R_EN      <= 1'b0;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            RREADY    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ADDR;
                        req_ready <= 1'b0;
                        ARADDR    <= req_addr;
                        ARVALID   <= 1'b1;
                        R_EN      <= 1'b1;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        state   <= DATA;
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                    end else if (tmo_expired) begin
                        state     <= RESP;
                        ARVALID   <= 1'b0;
                        R_EN      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                    end
                end
                DATA: begin
                    if (RVALID) begin
                        state     <= RESP;
                        RREADY    <= 1'b0;
                        R_EN      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= RDATA;
                        rsp_err   <= map_rresp(RRESP);
                    end else if (tmo_expired) begin
                        state     <= RESP;
                        RREADY    <= 1'b0;
                        R_EN      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_master.sv
// Directed + randomized bench for axi_read_master; expected responses come
// from a cycle-budget model of the handshake/timeout rules and a memory array.
module tb_axi_read_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_err;
    logic          R_EN;
    logic          ARVALID;
    logic          ARREADY;
    logic [AW-1:0] ARADDR;
    logic          RVALID;
    logic          RREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;

    logic [DW-1:0] mem [32];
    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int txn    = 0;

    axi_read_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .R_EN      (R_EN),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({req_ready, rsp_valid, rsp_data, rsp_err, R_EN, ARVALID, ARADDR, RREADY});
    endfunction

    // One full read. ar_dly/r_dly: idle cycles the slave waits before ARREADY/RVALID
    // (values >= TO mean it never answers in time). hold: cycles rsp_ready stays low.
    task automatic run_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                            input logic [1:0] rresp, input int hold);
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_err;
        int            exp_lat;
        int            hs_ar;
        int            hs_r;
        txn++;
        hs_ar = ar_dly + 1;
        hs_r  = ar_dly + r_dly + 2;
        if (ar_dly >= TO) begin
            exp_err = 2'b10; exp_data = '0; exp_lat = TO;
        end else if (r_dly >= TO) begin
            exp_err = 2'b10; exp_data = '0; exp_lat = hs_ar + TO;
        end else begin
            exp_err  = (rresp >= 2'd2) ? 2'b01 : 2'b00;
            exp_data = mem[addr];
            exp_lat  = hs_r;
        end

        check($sformatf("t%0d req_ready before", txn), 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        check($sformatf("t%0d addr phase", txn), 64'({ARVALID, R_EN, req_ready, ARADDR}),
              64'({1'b1, 1'b1, 1'b0, addr}));

        for (int c = 1; c <= exp_lat; c++) begin
            ARREADY = (c == hs_ar);
            if (c <= hs_ar) begin
                RVALID = 1'b1; RDATA = ~mem[addr]; RRESP = 2'b11;
            end else if (c == hs_r) begin
                RVALID = 1'b1; RDATA = mem[addr]; RRESP = rresp;
            end else begin
                RVALID = 1'b0; RDATA = DW'($urandom); RRESP = 2'($urandom);
            end
            tick();
            if (c == hs_ar && c < exp_lat)
                check($sformatf("t%0d data phase", txn), 64'({ARVALID, RREADY, R_EN}), 64'b011);
            if (c == exp_lat - 1)
                check($sformatf("t%0d no early rsp", txn), 64'(rsp_valid), 64'd0);
        end
        ARREADY = 1'b0;
        RVALID  = 1'b0;

        check($sformatf("t%0d rsp_valid", txn), 64'(rsp_valid), 64'd1);
        check($sformatf("t%0d rsp_data", txn), 64'(rsp_data), 64'(exp_data));
        check($sformatf("t%0d rsp_err", txn), 64'(rsp_err), 64'(exp_err));
        check($sformatf("t%0d axi idle in resp", txn), 64'({R_EN, ARVALID, RREADY, req_ready}), 64'd0);

        if (hold > 0) begin
            for (int h = 0; h < hold; h++) tick();
            check($sformatf("t%0d held rsp", txn), 64'({rsp_valid, req_ready, rsp_err, rsp_data}),
                  64'({1'b1, 1'b0, exp_err, exp_data}));
        end

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check($sformatf("t%0d rsp done", txn), 64'({rsp_valid, req_ready}), 64'b01);
    endtask

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RDATA     = '0;
        RRESP     = 2'b00;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[9] = 32'hDEADBEEF;

        #12;
        check("reset outputs", all_outputs(), 64'd0);
        ARESETn = 1'b1;
        #1;
        check("req_ready low before first edge", 64'(req_ready), 64'd0);
        tick();
        check("req_ready after first edge", 64'(req_ready), 64'd1);

        run_read(5'd9, 1, 0, 2'b01, 0);           // single read, EXOKAY -> ok
        run_read(5'd12, 0, 1, 2'b10, 0);          // SLVERR -> slave error
        run_read(5'd4, 1000, 0, 2'b00, 0);        // ARREADY never -> timeout in ADDR
        run_read(5'd17, 2, 1, 2'b00, 5);          // response held for 5 cycles
        run_read(5'd3, 0, 0, 2'b00, 0);           // back-to-back, minimum latency
        run_read(5'd31, 0, 0, 2'b11, 0);          // DECERR -> slave error
        run_read(5'd20, 15, 0, 2'b00, 0);         // ARREADY on the limit cycle wins
        run_read(5'd21, 0, 15, 2'b00, 0);         // RVALID on the limit cycle wins
        run_read(5'd22, 0, 16, 2'b00, 1);         // RVALID one cycle too late

        // Reset pulsed while waiting in DATA: transfer abandoned.
        check("mid reset req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = 5'd7;
        tick();
        req_valid = 1'b0;
        ARREADY   = 1'b1;
        tick();
        ARREADY = 1'b0;
        check("mid reset in DATA", 64'({RREADY, R_EN}), 64'b11);
        #3;
        ARESETn = 1'b0;
        #1;
        check("async reset outputs", all_outputs(), 64'd0);
        RVALID = 1'b1;
        RDATA  = mem[7];
        tick();
        tick();
        #2;
        ARESETn = 1'b1;
        tick();
        check("post reset state", 64'({req_ready, rsp_valid, ARVALID, RREADY, R_EN}), 64'b10000);
        tick();
        check("post reset no rsp", 64'({rsp_valid, rsp_data}), 64'd0);
        RVALID = 1'b0;

        for (int t = 0; t < 12; t++) begin
            int ar;
            int rd;
            ar = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) ar = 40;
            if ($urandom_range(0, 7) == 0) rd = 40;
            run_read(AW'($urandom), ar, rd, 2'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
